// File: rtl/cs_sequencer.sv
// Round-robin chip-select sequencer: arbitrates four requesters and drives a
// 2-to-4 decoder (dec_g/dec_a/dec_b) plus its decoded one-cold cs_n mirror.
module cs_sequencer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic       dec_g,
  output logic       dec_a,
  output logic       dec_b,
  output logic [3:0] cs_n,
  output logic       busy,
  output logic [1:0] grant_id
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  state_t     state, state_nx;
  logic [1:0] grant_nx;
  logic [1:0] last_grant, last_nx;
  logic [3:0] cnt, cnt_nx;
  logic       done, done_nx;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       dec_g_nx;
  logic [3:0] cs_n_nx;
  logic [3:0] ack_nx;
  logic       busy_nx;

  // Lowest offset from last_grant+1 wins; iterating downwards lets it overwrite.
  always_comb begin
    pick = last_grant;
    idx  = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = 2'(32'(last_grant) + i);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    last_nx  = last_grant;
    cnt_nx   = cnt;
    done_nx  = done;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          grant_nx = pick;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        cnt_nx   = '0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (!req[grant_id]) begin
          done_nx  = 1'b0;
          state_nx = RELEASE;
        end else if (cnt == WAIT_LIM) begin
          done_nx  = 1'b1;
          state_nx = RELEASE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      RELEASE: begin
        last_nx  = grant_id;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    dec_g_nx = (state_nx != ACCESS);
    cs_n_nx  = (state_nx == ACCESS) ? ~(4'b0001 << grant_nx) : '1;
    ack_nx   = (state_nx == RELEASE && done_nx) ? (4'b0001 << grant_nx) : '0;
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= 2'd3;
      cnt        <= '0;
      done       <= 1'b0;
      dec_g      <= 1'b1;
      cs_n       <= '1;
      ack        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      grant_id   <= grant_nx;
      last_grant <= last_nx;
      cnt        <= cnt_nx;
      done       <= done_nx;
      dec_g      <= dec_g_nx;
      cs_n       <= cs_n_nx;
      ack        <= ack_nx;
      busy       <= busy_nx;
    end
  end

  assign dec_a = grant_id[0];
  assign dec_b = grant_id[1];

endmodule

// File: doc/cs_sequencer.md
CS_SEQUENCER -- requirements
Module: cs_sequencer

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 2, extra ACCESS cycles beyond the first (legal 0..15).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester access request, level, held until ack.
REQ-005 SHALL have port: ack  output  4  per-requester completion strobe, one-hot, one cycle.
REQ-006 SHALL have port: dec_g  output  1  2-to-4 decoder disable, 1 = all selects inactive.
REQ-007 SHALL have port: dec_a  output  1  decoder select LSB (grant_id[0]).
REQ-008 SHALL have port: dec_b  output  1  decoder select MSB (grant_id[1]).
REQ-009 SHALL have port: cs_n  output  4  active-low one-cold chip selects, internally decoded mirror of dec_g/dec_a/dec_b.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: grant_id  output  2  index of current or last granted requester.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RELEASE; all outputs registered.
REQ-013 IDLE: dec_g=1, cs_n=1111, ack=0000; if req!=0, SHALL pick winner round-robin starting at (last_grant+1) mod 4, latch it into grant_id, go SETUP.
REQ-014 SETUP: exactly 1 cycle; dec_a/dec_b = grant; dec_g stays 1 (address setup before enable); cs_n=1111; go ACCESS.
REQ-015 ACCESS: dec_g=0; cs_n = 1110/1101/1011/0111 for {dec_b,dec_a} = 00/01/10/11; lasts exactly WAIT_CYCLES+1 cycles, then RELEASE with completion flag set.
REQ-016 ACCESS abort: if req[grant] deasserts in any ACCESS cycle, SHALL go RELEASE next edge with completion flag clear.
REQ-017 RELEASE: 1 cycle; dec_g=1, cs_n=1111; ack[grant]=1 only if completion flag set, else ack=0000; last_grant<=grant; go IDLE.
REQ-018 dec_a/dec_b SHALL hold the grant from SETUP through RELEASE; they change only on IDLE->SETUP.
REQ-019 Latency: req sampled at edge N -> SETUP after N, cs_n active after N+1 through N+1+WAIT_CYCLES, ack high after N+2+WAIT_CYCLES, IDLE after N+3+WAIT_CYCLES.
REQ-020 Minimum one IDLE cycle between consecutive grants; back-to-back requests SHALL still rotate.
REQ-021 Changes on non-granted req bits during SETUP/ACCESS/RELEASE SHALL be ignored until next IDLE.
REQ-022 Wait counter width SHALL be 4 bits; counter SHALL never wrap within an access.
REQ-023 At most one cs_n bit low and at most one ack bit high in any cycle; cs_n low only in ACCESS.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, dec_g=1, dec_a=0, dec_b=0, cs_n=1111, ack=0000, busy=0, grant_id=0, last_grant=3, counter=0, independent of clk.
REQ-025 Reset asserted mid-ACCESS SHALL drop cs_n to 1111 without ack; first grant after release of rst_n SHALL go to the lowest-index active requester from 0.

Verification
REQ-026 WAIT_CYCLES=2, req=0010 held: SETUP dec_b,dec_a=01 dec_g=1; then cs_n=1101 exactly 3 cycles; then ack=0010 one cycle; busy low after.
REQ-027 req=1111 held, ack each requester drops its bit: grant order 0,1,2,3; cs_n sequence 1110,1101,1011,0111; IDLE cycle between each.
REQ-028 req=0100, drop req[2] in 2nd ACCESS cycle: RELEASE next edge, ack stays 0000, cs_n=1111, next grant pointer past 2.
REQ-029 WAIT_CYCLES=0, req=1000: cs_n=0111 for exactly 1 cycle, ack=1000 the following cycle.
REQ-030 rst_n pulsed low mid-ACCESS (req=0001): cs_n=1111 and dec_g=1 asynchronously, no ack; after release with req=0011, requester 0 granted first.
